// File: rtl/canvas_brush_if.sv
// Read-request and pixel-memory port bundle between the brush controller and its neighbours.
// The controller takes the slave view; the I2C side and the memory take the master view.
interface canvas_brush_if #(
  parameter int GRID_BITS = 4
) ();
  logic                   rd_req;
  logic [2*GRID_BITS-1:0] rd_addr;
  logic                   rd_ack;
  logic                   rd_valid;
  logic [2:0]             rd_data;
  logic                   mem_en;
  logic                   mem_we;
  logic [2*GRID_BITS-1:0] mem_addr;
  logic [2:0]             mem_wdata;
  logic [2:0]             mem_rdata;

  modport slave (
    input  rd_req, rd_addr, mem_rdata,
    output rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, mem_rdata,
    input  rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/canvas_brush_ctrl.sv
// Cursor/paint controller: debounced direction buttons with auto-repeat move a cursor,
// each move paints one pixel, and paint writes share the memory port with I2C reads.
module canvas_brush_ctrl #(
  parameter int GRID_BITS       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             buttons,
  input  logic [2:0]             rgb_sel,
  input  logic                   brush,
  canvas_brush_if.slave          bus,
  output logic [2*GRID_BITS-1:0] cursor,
  output logic                   paint_busy
);

  localparam int AW = 2 * GRID_BITS;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RP_TC = RW'(REPEAT_CYCLES - 1);

  logic [3:0]    sync1, sync2, deb, ev;
  logic [DW-1:0] db_cnt [4];
  logic [RW-1:0] rp_cnt [4];

  // ev is a registered one-cycle pulse: press edge or repeat tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      ev    <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
        rp_cnt[i] <= '0;
      end
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TC) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
          if (!deb[i]) ev[i] <= 1'b1;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end

        if (!deb[i]) begin
          rp_cnt[i] <= '0;
        end else if (rp_cnt[i] == RP_TC) begin
          rp_cnt[i] <= '0;
          ev[i]     <= 1'b1;
        end else begin
          rp_cnt[i] <= rp_cnt[i] + RW'(1);
        end
      end
    end
  end

  logic                 mv_x, mv_y, take;
  logic [GRID_BITS-1:0] cur_x, cur_y, nx, ny;

  always_comb begin
    cur_x = cursor[GRID_BITS-1:0];
    cur_y = cursor[AW-1:GRID_BITS];
    mv_x  = ev[1] ^ ev[0];
    mv_y  = ev[3] ^ ev[2];
    nx    = cur_x;
    ny    = cur_y;
    if (mv_x) nx = ev[1] ? cur_x + GRID_BITS'(1) : cur_x - GRID_BITS'(1);
    if (mv_y) ny = ev[2] ? cur_y + GRID_BITS'(1) : cur_y - GRID_BITS'(1);
    take  = (mv_x | mv_y) & ~paint_busy;
  end

  logic          mem_en, mem_we, rd_ack, rd_valid, last_w;
  logic [AW-1:0] mem_addr, wr_addr;
  logic [2:0]    mem_wdata, wr_data, rd_data_q;
  logic          wr_pend, rd_pend, gnt_w, gnt_r;

  // Requests already being served this cycle are masked so they are not granted twice.
  always_comb begin
    wr_pend = paint_busy & ~(mem_en & mem_we);
    rd_pend = bus.rd_req & ~rd_ack;
    gnt_w   = wr_pend & (~rd_pend | ~last_w);
    gnt_r   = rd_pend & ~gnt_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor     <= '0;
      paint_busy <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data_q  <= '0;
      last_w     <= 1'b0;
    end else begin
      if (take) begin
        cursor     <= {ny, nx};
        paint_busy <= 1'b1;
        wr_addr    <= {ny, nx};
        wr_data    <= brush ? rgb_sel : 3'b000;
      end else if (mem_en && mem_we) begin
        paint_busy <= 1'b0;
      end

      mem_en   <= gnt_w | gnt_r;
      mem_we   <= gnt_w;
      rd_ack   <= gnt_r;
      rd_valid <= rd_ack;
      if (gnt_w) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        last_w    <= 1'b1;
      end else if (gnt_r) begin
        mem_addr  <= bus.rd_addr;
        last_w    <= 1'b0;
      end
      if (rd_valid) rd_data_q <= bus.mem_rdata;
    end
  end

  // Memory data arrives in the rd_valid cycle, so pass it through then and hold it afterwards.
  assign bus.rd_data   = rd_valid ? bus.mem_rdata : rd_data_q;
  assign bus.rd_ack    = rd_ack;
  assign bus.rd_valid  = rd_valid;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_canvas_brush_ctrl.sv
// Directed bench for canvas_brush_ctrl with a small synchronous pixel memory model.
module tb_canvas_brush_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] buttons = 4'b0000;
  logic [2:0] rgb_sel = 3'b000;
  logic       brush = 1'b1;
  logic [7:0] cursor;
  logic       paint_busy;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int valid_cnt = 0;

  logic [2:0] mem [256];

  canvas_brush_if #(.GRID_BITS(4)) bus ();

  canvas_brush_ctrl #(
    .GRID_BITS(4), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .rgb_sel(rgb_sel), .brush(brush),
    .bus(bus), .cursor(cursor), .paint_busy(paint_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en && bus.mem_we) wr_cnt++;
    if (bus.rd_valid) valid_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    buttons = 4'b0000;
    bus.rd_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 3'b110;
    bus.mem_rdata = 3'b000;
    bus.rd_req = 1'b0;
    bus.rd_addr = 8'h00;

    // 1: reset values, clean right press, repeat spacing
    do_reset();
    check_val("rst_cursor", 32'(cursor), 'h00);
    check_val("rst_busy", 32'(paint_busy), 0);
    check_val("rst_mem_en", 32'(bus.mem_en), 0);
    check_val("rst_mem_we", 32'(bus.mem_we), 0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_val("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check_val("rst_rd_ack", 32'(bus.rd_ack), 0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 0);
    check_val("rst_rd_data", 32'(bus.rd_data), 0);
    buttons = 4'b0010; brush = 1'b1; rgb_sel = 3'b101;
    tick(6);
    check_val("t1_cursor_early", 32'(cursor), 'h00);
    tick(1);
    check_val("t1_cursor", 32'(cursor), 'h01);
    check_val("t1_busy", 32'(paint_busy), 1);
    check_val("t1_no_grant_yet", 32'(bus.mem_en), 0);
    tick(1);
    check_val("t1_wr_en", 32'(bus.mem_en), 1);
    check_val("t1_wr_we", 32'(bus.mem_we), 1);
    check_val("t1_wr_addr", 32'(bus.mem_addr), 'h01);
    check_val("t1_wr_data", 32'(bus.mem_wdata), 'h5);
    tick(1);
    check_val("t1_busy_clr", 32'(paint_busy), 0);
    check_val("t1_idle_en", 32'(bus.mem_en), 0);
    check_val("t1_idle_addr_hold", 32'(bus.mem_addr), 'h01);
    tick(5);
    check_val("t1_no_early_repeat", 32'(cursor), 'h01);
    tick(1);
    check_val("t1_repeat", 32'(cursor), 'h02);
    buttons = 4'b0000;
    tick(12);
    check_val("t1_after_release", 32'(cursor), 'h02);
    check_val("t1_wr_cnt", 32'(wr_cnt), 2);

    // 2: bounce rejection, then wrap and repeats on left
    do_reset();
    for (int k = 0; k < 5; k++) begin
      buttons = 4'b0001; tick(2);
      buttons = 4'b0000; tick(2);
    end
    check_val("t2_bounce_cursor", 32'(cursor), 'h00);
    check_val("t2_bounce_busy", 32'(paint_busy), 0);
    buttons = 4'b0001;
    tick(7);
    check_val("t2_wrap", 32'(cursor), 'h0F);
    tick(1);
    check_val("t2_wrap_wr_addr", 32'(bus.mem_addr), 'h0F);
    tick(22);
    check_val("t2_two_repeats", 32'(cursor), 'h0D);
    tick(1);
    check_val("t2_three_repeats", 32'(cursor), 'h0C);
    buttons = 4'b0000;
    tick(12);
    check_val("t2_hold_after_release", 32'(cursor), 'h0C);

    // 3: vertical cancellation with right, then up+down alone
    buttons = 4'b1110;
    tick(7);
    check_val("t3_x_only", 32'(cursor), 'h0D);
    buttons = 4'b0000;
    tick(1);
    check_val("t3_wr_addr", 32'(bus.mem_addr), 'h0D);
    tick(12);
    buttons = 4'b1100;
    tick(7);
    check_val("t3_cancel_cursor", 32'(cursor), 'h0D);
    check_val("t3_cancel_busy", 32'(paint_busy), 0);
    buttons = 4'b0000;
    tick(13);
    check_val("t3_cancel_cursor_late", 32'(cursor), 'h0D);
    check_val("t3_wr_cnt", 32'(wr_cnt), 7);

    // 4: eraser
    do_reset();
    brush = 1'b0; rgb_sel = 3'b111;
    buttons = 4'b0100;
    tick(7);
    check_val("t4_cursor", 32'(cursor), 'h10);
    buttons = 4'b0000;
    tick(1);
    check_val("t4_wr_we", 32'(bus.mem_we), 1);
    check_val("t4_wr_addr", 32'(bus.mem_addr), 'h10);
    check_val("t4_wr_data", 32'(bus.mem_wdata), 'h0);
    tick(12);

    // 5: write and read contend with last = R; write first, then read returns it
    do_reset();
    brush = 1'b1; rgb_sel = 3'b011;
    buttons = 4'b0100;
    tick(7);
    check_val("t5_cursor", 32'(cursor), 'h10);
    buttons = 4'b0000;
    bus.rd_req = 1'b1; bus.rd_addr = 8'h10;
    tick(1);
    check_val("t5_wr_first_we", 32'(bus.mem_we), 1);
    check_val("t5_wr_first_data", 32'(bus.mem_wdata), 'h3);
    check_val("t5_no_ack_yet", 32'(bus.rd_ack), 0);
    tick(1);
    check_val("t5_ack", 32'(bus.rd_ack), 1);
    check_val("t5_rd_en", 32'(bus.mem_en), 1);
    check_val("t5_rd_we", 32'(bus.mem_we), 0);
    check_val("t5_rd_addr", 32'(bus.mem_addr), 'h10);
    bus.rd_req = 1'b0;
    tick(1);
    check_val("t5_valid", 32'(bus.rd_valid), 1);
    check_val("t5_data", 32'(bus.rd_data), 'h3);
    check_val("t5_ack_clr", 32'(bus.rd_ack), 0);
    tick(1);
    check_val("t5_valid_clr", 32'(bus.rd_valid), 0);
    check_val("t5_data_hold", 32'(bus.rd_data), 'h3);

    // 6: reset during the rd_ack cycle
    tick(10);
    bus.rd_req = 1'b1; bus.rd_addr = 8'h10;
    tick(1);
    check_val("t6_ack", 32'(bus.rd_ack), 1);
    rst_n = 1'b0;
    #1;
    bus.rd_req = 1'b0;
    check_val("t6_cursor", 32'(cursor), 'h00);
    check_val("t6_ack_clr", 32'(bus.rd_ack), 0);
    check_val("t6_mem_en", 32'(bus.mem_en), 0);
    check_val("t6_mem_addr", 32'(bus.mem_addr), 0);
    check_val("t6_mem_wdata", 32'(bus.mem_wdata), 0);
    tick(1);
    check_val("t6_no_valid", 32'(bus.rd_valid), 0);
    check_val("t6_rd_data", 32'(bus.rd_data), 0);
    check_val("t6_busy", 32'(paint_busy), 0);
    check_val("t6_valid_cnt", 32'(valid_cnt), 1);
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/canvas_brush_ctrl.md
# canvas_brush_ctrl

Cursor and paint controller for the canvas design. It sits between the pushbutton/switch inputs of the canvas top level and the single-port pixel memory. It debounces the four direction buttons and moves a cursor over the grid, with auto-repeat while a button is held. After every move it paints the destination pixel with the selected colour, or with 0 in eraser mode. It also arbitrates the memory port between these paint writes and pixel reads requested by the I2C slave.

## Interface
- `GRID_BITS`, default 4: the grid is 2^GRID_BITS × 2^GRID_BITS pixels; x and y are each GRID_BITS wide.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a debounced button changes state.
- `REPEAT_CYCLES`, default 2500000: auto-repeat period while a button stays pressed.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `buttons` in 4: active-high, asynchronous. [3]=up, [2]=down, [1]=right, [0]=left.
- `rgb_sel` in 3: {R,G,B} paint colour (level).
- `brush` in 1: 1 = brush, 0 = eraser (level).
- `rd_req` in 1: I2C read request; held until `rd_ack`.
- `rd_addr` in 2·GRID_BITS: requested pixel, {y,x}; stable while `rd_req` is high.
- `rd_ack` out 1: one-cycle pulse; the read was granted.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is valid.
- `rd_data` out 3: pixel colour read.
- `mem_en` out 1: memory port enable.
- `mem_we` out 1: write strobe; only meaningful when `mem_en`=1.
- `mem_addr` out 2·GRID_BITS: {y,x}.
- `mem_wdata` out 3: write colour.
- `mem_rdata` in 3: synchronous read data, valid the cycle after `mem_en`=1 with `mem_we`=0.
- `cursor` out 2·GRID_BITS: current {y,x}.
- `paint_busy` out 1: a paint write is pending.

## Operation
- **Input sync.** `buttons` pass through a 2-flop synchronizer. `rgb_sel` and `brush` are sampled when the move event is taken (treated as quasi-static).
- **Debounce.** One counter per button.
  - The counter resets whenever the synced input equals the debounced state.
  - Otherwise it counts up. On reaching DEBOUNCE_CYCLES−1, the debounced state flips and the counter clears.
  - Debounced reset state is 0 (released).
- **Move events.** A debounced 0→1 edge produces one event for that button.
  - While the button stays debounced-1, a per-button repeat counter produces a further event every REPEAT_CYCLES.
  - The repeat counter clears on release.
- **Cursor update.** Evaluated every cycle in which any event occurs and `paint_busy`=0.
  - Up and down in the same cycle cancel; right and left in the same cycle cancel. x and y may both change in one cycle.
  - Up decrements y, down increments y, right increments x, left decrements x.
  - Arithmetic is modulo 2^GRID_BITS (wrap: x=0 with left gives the maximum; the maximum with right gives 0).
  - If the update is a net zero move, nothing happens and no paint is issued.
  - Otherwise the cursor takes the new value, `paint_busy` sets, and the pending write latches address = new cursor and data = `brush` ? `rgb_sel` : 3'b000.
- **Dropped events.** Events arriving while `paint_busy`=1 are dropped; they are not queued.
- **Arbiter.** Round-robin between the pending write (W) and `rd_req` (R). A 1-bit `last` register is reset to R.
  - Only one pending: that one is granted.
  - Both pending: the one opposite to `last` is granted. `last` updates on every grant.
- **Write grant.** `mem_en`=1, `mem_we`=1 for one cycle; `paint_busy` clears at the end of that cycle.
- **Read grant.** `mem_en`=1, `mem_we`=0, `mem_addr`=`rd_addr`, and `rd_ack`=1 in the same cycle.
  - The next cycle, `rd_valid`=1 and `rd_data`=`mem_rdata`, registered in that cycle.
  - A new read may be granted in the `rd_valid` cycle (back-to-back reads give one grant per cycle).
- **Idle outputs.** When there is no grant, `mem_en`=0 and `mem_we`=0, and `mem_addr`/`mem_wdata` hold their last value.

## Timing
- **Reset values:** cursor = 0, `paint_busy` = 0, `mem_en`/`mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rd_ack`/`rd_valid` = 0, `rd_data` = 0. All debounce and repeat counters are 0 and `last` = R.
- **Press to cursor.** A clean press is visible at the synchronizer output 2 cycles after the input changes. The debounced state flips DEBOUNCE_CYCLES cycles later. The cursor updates on the next edge after the event cycle.
- **Write latency.** The memory write occurs 1 cycle after the cursor update if uncontested, or 2 cycles if a read wins the tie.
- **Read latency.** `rd_ack` comes at least 1 cycle after `rd_req` is sampled high (it is a registered grant). `rd_valid` follows `rd_ack` by exactly 1 cycle.
- **Reset mid-operation.** Asserting `rst_n` low clears everything immediately. A pending paint or in-flight read is lost and no `rd_valid` is produced.

## Test plan
Bench parameters: GRID_BITS=4, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.

1. **Reset, then clean right press.** Reset, then hold `buttons`=0010 with `brush`=1 and `rgb_sel`=101. Required: cursor goes to 0x01, then one write with addr 0x01 and wdata 101; no second move before 8 more held cycles.
2. **Bounce rejection and wrap.** Toggle left every 2 cycles for 20 cycles: the cursor stays at 0. Then hold left steady: cursor x goes to 0xF (wrap). Continue holding for 24 cycles: 3 further repeats give x=0xC.
3. **Cancellation.** Press up and down together with right: only x changes. Press up+down alone: no move and no write.
4. **Eraser.** Set `brush`=0 with `rgb_sel`=111 and make a down move. Required: cursor 0x10, write wdata 000 at addr 0x10.
5. **Contention.** Hold `rd_req` with `rd_addr`=0x10 and trigger a move in the same cycle (`last`=R). Required: the write is granted first, `rd_ack` comes the next cycle, and `rd_valid` the cycle after with `rd_data` = the value just written.
6. **Reset mid-read.** Assert `rst_n` low in the `rd_ack` cycle. Required: no `rd_valid`, all outputs at their reset values, cursor = 0.
